// File: rtl/sha2_pkg.sv
// Shared constants and FSM state type for the SHA-256 message padder.
// Contents: block/word/length-field widths, the 0x80 pad marker byte, the last
// marker byte offset that still leaves room for the length field, and the
// padder state enum.
package sha2_pkg;

  localparam int unsigned SHA2_BLK_W        = 512;
  localparam int unsigned SHA2_WORD_W       = 32;
  localparam int unsigned SHA2_LEN_FIELD_W  = 64;
  localparam logic [7:0]  SHA2_PAD_MARKER   = 8'h80;
  // Highest marker byte offset that still leaves bytes 56..63 for the length.
  localparam int unsigned SHA2_MAX_SINGLE_L = 55;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StEmit,
    StExtra,
    StFlush
  } sha2_state_e;

endpackage

// File: rtl/sha2_pad_ctrl_if.sv
// Handshake bundle for the SHA-256 padder.
// Word side : in_data/in_valid/in_last/in_bytes from the host, in_ready back.
// Block side: blk_data/blk_valid/blk_first/blk_last to the core, blk_ready back.
// modport master: host + compression core side; modport slave: the padder.
interface sha2_pad_ctrl_if;
  import sha2_pkg::*;

  logic [SHA2_WORD_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_last;
  logic [2:0]             in_bytes;
  logic                   in_ready;

  logic [SHA2_BLK_W-1:0]  blk_data;
  logic                   blk_valid;
  logic                   blk_ready;
  logic                   blk_first;
  logic                   blk_last;

  modport master (
    output in_data, in_valid, in_last, in_bytes, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_first, blk_last
  );

  modport slave (
    input  in_data, in_valid, in_last, in_bytes, blk_ready,
    output in_ready, blk_data, blk_valid, blk_first, blk_last
  );

endinterface

// File: rtl/sha2_pad_mask.sv
// Last-word byte mask and pad-marker insertion.
// Ports:
//   in_data         final message word, first byte in [31:24]
//   in_bytes        valid bytes in that word (0..4)
//   masked          word with trailing bytes cleared and 0x80 at offset in_bytes
//   marker_overflow word is full; the marker belongs in the next slot
// Build option SHA2_PAD_BYTE_LAST_EN: when undefined the word is always treated
// as full (whole-word messages) and no mask logic is generated.
module sha2_pad_mask
  import sha2_pkg::*;
(
  input  logic [SHA2_WORD_W-1:0] in_data,
  input  logic [2:0]             in_bytes,
  output logic [SHA2_WORD_W-1:0] masked,
  output logic                   marker_overflow
);

`ifdef SHA2_PAD_BYTE_LAST_EN
  always_comb begin
    masked          = '0;
    // Counts above 4 are treated as a full word.
    marker_overflow = (in_bytes >= 3'd4);
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < in_bytes) begin
        masked[31-8*b -: 8] = in_data[31-8*b -: 8];
      end else if (3'(b) == in_bytes) begin
        masked[31-8*b -: 8] = SHA2_PAD_MARKER;
      end
    end
  end
`else
  logic [2:0] unused_bytes;
  assign unused_bytes    = in_bytes;
  assign masked          = in_data;
  assign marker_overflow = 1'b1;
`endif

endmodule

// File: rtl/sha2_pad_ctrl.sv
// Streaming SHA-256 padder / block sequencer.
// Packs 32-bit big-endian words into 512-bit blocks, appends the 0x80 marker,
// zero fill and the 64-bit bit length, emitting one or two final blocks.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         begins a new message (ignored while busy)
//   bus           word input and block output handshakes (slave modport)
//   msg_bits      running message length in bits
//   busy          high from start until the final block handshake
//   err_overflow  sticky msg_bits carry-out, cleared by start
// Build option SHA2_PAD_BYTE_LAST_EN enables byte-granular final words
// (in_bytes honoured); otherwise every word counts as 4 bytes.
module sha2_pad_ctrl
  import sha2_pkg::*;
#(
  parameter int unsigned LEN_W         = 64,
  parameter int unsigned WORDS_PER_BLK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  sha2_pad_ctrl_if.slave   bus,
  output logic [LEN_W-1:0] msg_bits,
  output logic             busy,
  output logic             err_overflow
);

  localparam int unsigned SumW = LEN_W + 7;

  sha2_state_e state_q, state_d;
  logic [4:0]             wi_q, wi_d;
  logic [SHA2_WORD_W-1:0] words_q [WORDS_PER_BLK];
  logic [SHA2_WORD_W-1:0] words_d [WORDS_PER_BLK];
  logic [LEN_W-1:0]       bits_q, bits_d;
  logic err_q, err_d;
  logic first_q, first_d;
  logic last_q, last_d;
  logic extra_q, extra_d;
  logic mpend_q, mpend_d;

  logic [SHA2_WORD_W-1:0]      masked;
  logic                        marker_overflow;
  logic [2:0]                  nb;
  logic [5:0]                  add_bits;
  logic [SumW-1:0]             sum;
  logic [6:0]                  lpos;
  logic [SHA2_LEN_FIELD_W-1:0] len_acc;
  logic [SHA2_LEN_FIELD_W-1:0] len_hold;

  sha2_pad_mask u_mask (
    .in_data         (bus.in_data),
    .in_bytes        (bus.in_bytes),
    .masked          (masked),
    .marker_overflow (marker_overflow)
  );

  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    words_d = words_q;
    bits_d  = bits_q;
    err_d   = err_q;
    first_d = first_q;
    last_d  = last_q;
    extra_d = extra_q;
    mpend_d = mpend_q;

    nb       = marker_overflow ? 3'd4 : bus.in_bytes;
    add_bits = bus.in_last ? {nb, 3'b000} : 6'd32;
    sum      = SumW'(bits_q) + SumW'(add_bits);
    // Byte offset of the marker within the block (64 = next block).
    lpos     = {wi_q, 2'b00} + 7'(nb);
    len_acc  = SHA2_LEN_FIELD_W'(sum[LEN_W-1:0]);
    len_hold = SHA2_LEN_FIELD_W'(bits_q);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          wi_d    = '0;
          bits_d  = '0;
          err_d   = 1'b0;
          first_d = 1'b1;
          state_d = StAccum;
        end
      end

      StAccum: begin
        if (bus.in_valid) begin
          bits_d = sum[LEN_W-1:0];
          if (|sum[SumW-1:LEN_W]) begin
            err_d = 1'b1;
          end
          if (!bus.in_last) begin
            words_d[wi_q[3:0]] = bus.in_data;
            wi_d               = wi_q + 5'd1;
            if (wi_q == 5'(WORDS_PER_BLK - 1)) begin
              last_d  = 1'b0;
              extra_d = 1'b0;
              mpend_d = 1'b0;
              state_d = StEmit;
            end
          end else begin
            // Slots past the last word hold stale data from earlier blocks.
            for (int j = 0; j < WORDS_PER_BLK; j++) begin
              if (5'(j) == wi_q) begin
                words_d[j] = masked;
              end else if (5'(j) > wi_q) begin
                words_d[j] = (marker_overflow && (5'(j) == wi_q + 5'd1)) ?
                             {SHA2_PAD_MARKER, 24'h0} : '0;
              end
            end
            if (lpos <= 7'(SHA2_MAX_SINGLE_L)) begin
              words_d[WORDS_PER_BLK-2] = len_acc[63:32];
              words_d[WORDS_PER_BLK-1] = len_acc[31:0];
              last_d  = 1'b1;
              extra_d = 1'b0;
              mpend_d = 1'b0;
            end else begin
              last_d  = 1'b0;
              extra_d = 1'b1;
              mpend_d = (lpos == 7'd64);
            end
            state_d = StEmit;
          end
        end
      end

      StEmit: begin
        if (bus.blk_ready) begin
          first_d = 1'b0;
          if (last_q) begin
            state_d = StFlush;
          end else if (extra_q) begin
            state_d = StExtra;
          end else begin
            wi_d    = '0;
            state_d = StAccum;
          end
        end
      end

      StExtra: begin
        for (int j = 0; j < WORDS_PER_BLK; j++) begin
          words_d[j] = '0;
        end
        words_d[0]               = mpend_q ? {SHA2_PAD_MARKER, 24'h0} : '0;
        words_d[WORDS_PER_BLK-2] = len_hold[63:32];
        words_d[WORDS_PER_BLK-1] = len_hold[31:0];
        last_d  = 1'b1;
        extra_d = 1'b0;
        mpend_d = 1'b0;
        state_d = StEmit;
      end

      StFlush: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wi_q    <= '0;
      words_q <= '{default: '0};
      bits_q  <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      mpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      words_q <= words_d;
      bits_q  <= bits_d;
      err_q   <= err_d;
      first_q <= first_d;
      last_q  <= last_d;
      extra_q <= extra_d;
      mpend_q <= mpend_d;
    end
  end

  always_comb begin
    bus.blk_data = '0;
    for (int j = 0; j < WORDS_PER_BLK; j++) begin
      bus.blk_data[SHA2_BLK_W-1-32*j -: 32] = words_q[j];
    end
  end

  assign bus.in_ready  = (state_q == StAccum);
  assign bus.blk_valid = (state_q == StEmit);
  assign bus.blk_first = bus.blk_valid & first_q;
  assign bus.blk_last  = bus.blk_valid & last_q;
  assign busy          = (state_q == StAccum) || (state_q == StEmit) ||
                         (state_q == StExtra);
  assign msg_bits      = bits_q;
  assign err_overflow  = err_q;

endmodule

// File: tb/tb_sha2_pad_ctrl.sv
// Bench for sha2_pad_ctrl: directed and random messages checked against a
// byte-level SHA-256 padding model (append 0x80, zero to 56 mod 64, 64-bit
// length) built from the bytes actually sent.
module tb_sha2_pad_ctrl;
  import sha2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] msg_bits;
  logic        busy;
  logic        err_overflow;

  sha2_pad_ctrl_if bus ();

  sha2_pad_ctrl #(
    .LEN_W         (64),
    .WORDS_PER_BLK (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .msg_bits     (msg_bits),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  byte unsigned msg_q[$];
  logic [511:0] exp_q[$];
  logic [511:0] got_q[$];
  bit           got_first_q[$];
  bit           got_last_q[$];
  int           rdy_mode = 1;  // 0 random, 1 always ready, 2 stalled
  bit           pend;
  logic [511:0] pend_data;
  logic         pend_first, pend_last;
  bit           done;
  int           widx;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one clock from a negedge to the next, acting as the block consumer.
  task automatic cycle();
    case (rdy_mode)
      0:       bus.blk_ready = ($urandom_range(0, 2) != 0);
      1:       bus.blk_ready = 1'b1;
      default: bus.blk_ready = 1'b0;
    endcase
    if (pend) begin
      check("hold_valid", 512'(bus.blk_valid), 512'(1));
      check("hold_data", bus.blk_data, pend_data);
      check("hold_first", 512'(bus.blk_first), 512'(pend_first));
      check("hold_last", 512'(bus.blk_last), 512'(pend_last));
    end
    if (bus.blk_valid === 1'b1) begin
      if (bus.blk_ready) begin
        got_q.push_back(bus.blk_data);
        got_first_q.push_back(bus.blk_first);
        got_last_q.push_back(bus.blk_last);
        if (bus.blk_last === 1'b1) done = 1'b1;
        pend = 1'b0;
      end else begin
        pend       = 1'b1;
        pend_data  = bus.blk_data;
        pend_first = bus.blk_first;
        pend_last  = bus.blk_last;
      end
    end else begin
      pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb,
                           input bit blk_edge);
    bit acc = 1'b0;
    int n   = 0;
    int eff = 4;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_bytes = nb;
    while (!acc && n < 500) begin
      acc = (bus.in_ready === 1'b1);
      cycle();
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("word_accept", 512'(acc), 512'(1));
    if (blk_edge) check("blk_valid_latency", 512'(bus.blk_valid), 512'(1));
`ifdef SHA2_PAD_BYTE_LAST_EN
    if (last) eff = (nb > 3'd4) ? 4 : int'(nb);
`endif
    for (int b = 0; b < eff; b++) msg_q.push_back(d[31-8*b -: 8]);
  endtask

  task automatic begin_msg();
    msg_q.delete();
    got_q.delete();
    got_first_q.delete();
    got_last_q.delete();
    done  = 1'b0;
    pend  = 1'b0;
    widx  = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("busy_after_start", 512'(busy), 512'(1));
    check("bits_after_start", 512'(msg_bits), 512'(0));
  endtask

  task automatic send_bytes(input int nbytes, input bit empty_tail, input int mid_start);
    int       full = nbytes / 4;
    int       rem  = nbytes % 4;
    int       nonlast;
    logic [2:0] lastnb;
    bit       blk_edge;
    if (rem != 0) begin
      nonlast = full;
      lastnb  = 3'(rem);
    end else if (nbytes == 0 || empty_tail) begin
      nonlast = full;
      lastnb  = 3'd0;
    end else begin
      nonlast = full - 1;
      lastnb  = 3'd4;
    end
    for (int i = 0; i < nonlast; i++) begin
      if (i == mid_start) start = 1'b1;
      widx++;
      blk_edge = (widx == 16);
      if (blk_edge) widx = 0;
      send_word($urandom(), 1'b0, 3'($urandom_range(0, 4)), blk_edge);
      start = 1'b0;
      repeat ($urandom_range(0, 1)) cycle();
    end
    send_word($urandom(), 1'b1, lastnb, 1'b1);
  endtask

  task automatic finish_msg();
    int           n = 0;
    byte unsigned p[$];
    logic [63:0]  len;
    logic [511:0] blk;
    while (!done && n < 400) begin
      cycle();
      n++;
    end
    check("msg_done", 512'(done), 512'(1));
    len = 64'(msg_q.size()) * 64'd8;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*b+i];
      exp_q.push_back(blk);
    end
    check("blk_count", 512'(got_q.size()), 512'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("blk_data", got_q[i], exp_q[i]);
      check("blk_first", 512'(got_first_q[i]), 512'(i == 0));
      check("blk_last", 512'(got_last_q[i]), 512'(i == exp_q.size() - 1));
    end
    check("msg_bits", 512'(msg_bits), 512'(len));
    check("busy_done", 512'(busy), 512'(0));
    check("err_overflow", 512'(err_overflow), 512'(0));
    cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_blk_data"}, bus.blk_data, 512'(0));
    check({tag, "_blk_valid"}, 512'(bus.blk_valid), 512'(0));
    check({tag, "_blk_first"}, 512'(bus.blk_first), 512'(0));
    check({tag, "_blk_last"}, 512'(bus.blk_last), 512'(0));
    check({tag, "_in_ready"}, 512'(bus.in_ready), 512'(0));
    check({tag, "_busy"}, 512'(busy), 512'(0));
    check({tag, "_msg_bits"}, 512'(msg_bits), 512'(0));
    check({tag, "_err"}, 512'(err_overflow), 512'(0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.in_bytes  = '0;
    bus.blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // "abc" in one word
    rdy_mode = 1;
    begin_msg();
    send_word(32'h6162_6300, 1'b1, 3'd3, 1'b1);
    finish_msg();

    // Length boundaries around the single-block limit and a full block
    begin_msg(); send_bytes(55, 1'b0, -1); finish_msg();
    begin_msg(); send_bytes(56, 1'b0, -1); finish_msg();
    begin_msg(); send_bytes(62, 1'b0, -1); finish_msg();
    begin_msg(); send_bytes(64, 1'b0, -1); finish_msg();
    begin_msg(); send_bytes(64, 1'b1, -1); finish_msg();
    begin_msg(); send_bytes(0, 1'b0, -1);  finish_msg();

    // start pulsed mid-message must be ignored
    begin_msg(); send_bytes(90, 1'b0, 3); finish_msg();

    // Consumer stalls 10 cycles on the final block
    rdy_mode = 2;
    begin_msg();
    send_word(32'h6162_6300, 1'b1, 3'd3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready", 512'(bus.in_ready), 512'(0));
      check("stall_valid", 512'(bus.blk_valid), 512'(1));
      cycle();
    end
    rdy_mode = 1;
    finish_msg();

    // Reset in the middle of a block, then a clean message
    begin_msg();
    for (int i = 0; i < 10; i++) send_word($urandom(), 1'b0, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pend  = 1'b0;
    @(negedge clk);
    begin_msg();
    send_word(32'h6162_6300, 1'b1, 3'd3, 1'b1);
    finish_msg();

    // Random lengths with a randomly stalling consumer
    rdy_mode = 0;
    for (int k = 0; k < 25; k++) begin
      begin_msg();
      send_bytes($urandom_range(0, 200), 1'($urandom_range(0, 1)), -1);
      finish_msg();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha2_pad_ctrl.md
Name: sha2_pad_ctrl

Overview:
- Streaming SHA-256 message padder/block sequencer between the host word interface and the SHA-256 compression core.
- Packs 32-bit big-endian message words into 512-bit blocks and appends the 0x80 marker byte, zero fill and the 64-bit bit-length.
- Emits one or two final blocks as needed, using a valid/ready handshake on both sides.
- Replaces single-shot combinational padding, which is limited to 447-bit messages; this block handles arbitrary-length messages.

Parameters:
- LEN_W, 64, width of the message bit-length counter (1..64). The length field in the block is always 64 bits, zero-extended from LEN_W.
- WORDS_PER_BLK, 16, words per block. Fixed by SHA-256; do not override.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new message; ignored while busy
- in_data  in  32  message word; first byte in [31:24]
- in_valid  in  1  in_data valid
- in_last  in  1  word is the final message word
- in_bytes  in  3  valid bytes in the last word, 0..4; 0 means empty (data ignored); read only when in_last
- in_ready  out  1  word accepted when in_valid && in_ready
- blk_data  out  512  block; word 0 in [511:480]
- blk_valid  out  1  blk_data valid
- blk_ready  in  1  core accepts the block
- blk_first  out  1  block is the first of the message (core loads IV)
- blk_last  out  1  block is the final block (digest valid after it)
- msg_bits  out  LEN_W  running message length in bits
- busy  out  1  high from start until the final block handshake
- err_overflow  out  1  sticky length overflow flag; cleared by start

Behaviour:
- Reset: state IDLE. All outputs 0, including blk_data, msg_bits and err_overflow. Reset mid-message discards all partial data.
- States: IDLE, ACCUM, EMIT, EXTRA, FLUSH.
  - IDLE: on start, clear word index wi, msg_bits and err_overflow; set first_pend=1; go to ACCUM.
  - ACCUM: in_ready=1.
    - Each accepted non-last word is written at slot wi; wi++; msg_bits += 32.
    - When wi reaches 16, go to EMIT with blk_last=0.
  - Last word accepted in ACCUM:
    - msg_bits += 8*in_bytes.
    - Bytes beyond in_bytes are zeroed, and 0x80 is placed at byte offset in_bytes.
    - If in_bytes=4, 0x80 goes to byte 0 of slot wi+1.
    - Remaining slots are zeroed.
    - L = byte index of 0x80 within the block. If L <= 55, write the length into words 14-15 and go to EMIT with blk_last=1.
    - If L > 55, go to EMIT with blk_last=0 and set need_extra.
    - If 0x80 falls in slot 16 (block was full), set need_extra and marker_pend.
  - EMIT: blk_valid=1; blk_first=first_pend.
    - On blk_ready, clear first_pend.
    - Then: FLUSH if blk_last; EXTRA if need_extra; otherwise ACCUM with wi=0.
  - EXTRA: build the block in one cycle: word0 = marker_pend ? 0x80000000 : 0, words 1-13 = 0, words 14-15 = length. Go to EMIT with blk_last=1.
  - FLUSH: busy drops; return to IDLE next cycle.
- Latency: blk_valid rises the cycle after the 16th or last word handshake. The extra block is valid 2 cycles after the first block's handshake.
- blk_data, blk_first and blk_last stay stable while blk_valid && !blk_ready. in_ready=0 in every state except ACCUM.
- msg_bits carry out of LEN_W sets err_overflow. The counter wraps, and the block is still emitted.
- start asserted during ACCUM is ignored. in_bytes=0 with in_last places 0x80 at the current word's byte 0.

Optional Feature:
- Macro SHA2_PAD_BYTE_LAST_EN.
- Defined: in_bytes is honoured as above (byte-granular messages).
- Undefined: in_bytes is ignored and treated as 4; messages are whole 32-bit words. The byte-mask logic is not generated.

Decomposition:
- Package sha2_pkg holds: state enum, SHA2_BLK_W=512, SHA2_WORD_W=32, SHA2_LEN_FIELD_W=64, SHA2_PAD_MARKER=8'h80, SHA2_MAX_SINGLE_L=55.
- One sub-module, sha2_pad_mask: combinational last-word byte mask plus marker insert (in_data, in_bytes -> masked word, marker_overflow).

Test Plan:
- "abc": one word 0x61626300, in_bytes=3, last -> single block: word0 0x61626380, words 1-14 = 0, word15 0x00000018; blk_first=blk_last=1.
- 55-byte message -> one block, marker at byte 55, length 0x1B8. 56-byte message -> two blocks: second block is zeros plus length 0x1C0, blk_first on the first block only.
- 64-byte message (16 full words, last with in_bytes=4) -> block 1 holds data only (blk_last=0); block 2 word0 0x80000000, length 0x200.
- Empty message (in_last, in_bytes=0) -> block word0 0x80000000, rest 0, blk_first=blk_last=1.
- blk_ready held low 10 cycles -> blk_data stable, in_ready=0. Mid-block rst_n pulse -> all outputs 0, next start produces a correct "abc" digest block.
